// File: rtl/secded_scrub_ctrl_if.sv
// Memory-port and SECDED-decoder bundle between the scrubber (master) and memory/decoder (slave).
// Wires only: no latency. Request/grant handshake on the memory side; the decoder side is combinational.
interface secded_scrub_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [71:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [71:0]       mem_rdata;
    logic [71:0]       dec_data_in;
    logic [71:0]       dec_data_out;
    logic              dec_single_error;
    logic              dec_double_error;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, dec_data_in,
        input  mem_gnt, mem_rvalid, mem_rdata, dec_data_out, dec_single_error, dec_double_error
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, dec_data_in,
        output mem_gnt, mem_rvalid, mem_rdata, dec_data_out, dec_single_error, dec_double_error
    );
endinterface

// File: rtl/secded_scrub_ctrl.sv
// Background SECDED scrubber: read, decode, write back CEs, log UEs; >=5 cycles/word (6 with a CE).
// Yields the memory port whenever host_busy is high; a request stays pending until mem_gnt.
module secded_scrub_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CNT_W-1:0]  interval,
    input  logic              host_busy,
    secded_scrub_ctrl_if.master bus,
    output logic [CNT_W-1:0]  ce_count,
    output logic [CNT_W-1:0]  ue_count,
    output logic [ADDR_W-1:0] ue_addr,
    output logic              ue_irq,
    input  logic              irq_clr,
    output logic              pass_done
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_READ, S_RESP, S_CHECK, S_WRITE, S_NEXT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  timer_q;
    logic              req_q;
    logic              we_q;
    logic [71:0]       wr_buf_q;
    logic [71:0]       rd_buf_q;
    logic [CNT_W-1:0]  ce_q;
    logic [CNT_W-1:0]  ue_q;
    logic [ADDR_W-1:0] ue_addr_q;
    logic              ue_irq_q;
    logic              pass_q;

    logic [CNT_W-1:0]  ce_d;
    logic [CNT_W-1:0]  ue_d;
    logic              gnt_d;
    logic              last_d;

    // host_busy gates the request combinationally so the port is released in the same cycle.
    assign bus.mem_req     = req_q & ~host_busy;
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wr_buf_q;
    assign bus.dec_data_in = rd_buf_q;

    assign ce_count  = ce_q;
    assign ue_count  = ue_q;
    assign ue_addr   = ue_addr_q;
    assign ue_irq    = ue_irq_q;
    assign pass_done = pass_q;

    assign ce_d   = (ce_q == '1) ? ce_q : ce_q + CNT_W'(1);
    assign ue_d   = (ue_q == '1) ? ue_q : ue_q + CNT_W'(1);
    assign gnt_d  = bus.mem_req & bus.mem_gnt;
    assign last_d = (addr_q == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            timer_q   <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            wr_buf_q  <= '0;
            rd_buf_q  <= '0;
            ce_q      <= '0;
            ue_q      <= '0;
            ue_addr_q <= '0;
            ue_irq_q  <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            pass_q <= 1'b0;
            // A UE logged in CHECK below overrides this clear.
            if (irq_clr) begin
                ue_irq_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        timer_q <= interval;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (timer_q <= CNT_W'(1)) begin
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        state_q <= S_READ;
                    end else begin
                        timer_q <= timer_q - CNT_W'(1);
                    end
                end
                S_READ: begin
                    if (gnt_d) begin
                        req_q   <= 1'b0;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.mem_rvalid) begin
                        rd_buf_q <= bus.mem_rdata;
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // Both flags together is illegal and handled as uncorrectable.
                    if (bus.dec_double_error) begin
                        ue_q     <= ue_d;
                        ue_irq_q <= 1'b1;
                        if (!ue_irq_q || irq_clr) begin
                            ue_addr_q <= addr_q;
                        end
                        rd_buf_q <= '0;
                        pass_q   <= last_d;
                        state_q  <= S_NEXT;
                    end else if (bus.dec_single_error) begin
                        ce_q     <= ce_d;
                        wr_buf_q <= bus.dec_data_out;
                        req_q    <= 1'b1;
                        we_q     <= 1'b1;
                        state_q  <= S_WRITE;
                    end else begin
                        rd_buf_q <= '0;
                        pass_q   <= last_d;
                        state_q  <= S_NEXT;
                    end
                end
                S_WRITE: begin
                    if (gnt_d) begin
                        req_q    <= 1'b0;
                        we_q     <= 1'b0;
                        rd_buf_q <= '0;
                        pass_q   <= last_d;
                        state_q  <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    addr_q <= last_d ? '0 : addr_q + ADDR_W'(1);
                    if (enable) begin
                        timer_q <= interval;
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_secded_scrub_ctrl.sv
// Scoreboard bench for secded_scrub_ctrl: 4-word memory model, a duplicated-half mock decoder
// (halves differing in 1 bit = CE corrected to {lo,lo}, in >=2 bits = UE), 4-bit counters.
module tb_secded_scrub_ctrl;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              host_busy = 1'b0;
    logic              irq_clr = 1'b0;
    logic [CNT_W-1:0]  interval = '0;
    logic [CNT_W-1:0]  ce_count;
    logic [CNT_W-1:0]  ue_count;
    logic [ADDR_W-1:0] ue_addr;
    logic              ue_irq;
    logic              pass_done;

    secded_scrub_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    secded_scrub_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .interval(interval), .host_busy(host_busy),
        .bus(bus), .ce_count(ce_count), .ue_count(ue_count), .ue_addr(ue_addr),
        .ue_irq(ue_irq), .irq_clr(irq_clr), .pass_done(pass_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [71:0]       wdata;
    } txn_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pass_cnt = 0;
    int          t_mark;
    logic        gnt_en = 1'b1;
    logic [71:0] mem [0:DEPTH-1];
    logic [35:0] v [0:DEPTH-1] = '{36'h0_1234_5678, 36'h9_ABCD_EF01, 36'h3_3C3C_A5A5, 36'hF_0F0F_1111};
    txn_t        exp_q[$];
    int          rd_times[$];

    function automatic logic [71:0] good(input logic [35:0] x);
        return {x, x};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory model: grant follows gnt_en, read data one cycle after the grant.
    assign bus.mem_gnt = gnt_en;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_rvalid <= 1'b0;
            bus.mem_rdata  <= '0;
        end else begin
            bus.mem_rvalid <= bus.mem_req & bus.mem_gnt & ~bus.mem_we;
            bus.mem_rdata  <= mem[bus.mem_addr[1:0]];
        end
    end

    logic [35:0] dec_diff;
    assign dec_diff             = bus.dec_data_in[71:36] ^ bus.dec_data_in[35:0];
    assign bus.dec_data_out     = {bus.dec_data_in[35:0], bus.dec_data_in[35:0]};
    assign bus.dec_single_error = ($countones(dec_diff) == 1);
    assign bus.dec_double_error = ($countones(dec_diff) >= 2);

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every accepted memory request.
    always @(negedge clk) begin
        txn_t t;
        if (rst_n && host_busy) chk("req_while_busy", bus.mem_req, 0);
        if (rst_n && bus.mem_req && bus.mem_gnt) begin
            if (!bus.mem_we) rd_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_txn", {bus.mem_we, bus.mem_addr}, '1);
            end else begin
                t = exp_q.pop_front();
                chk("txn_we", bus.mem_we, t.we);
                chk("txn_addr", bus.mem_addr, t.addr);
                if (t.we) chk("txn_wdata", bus.mem_wdata, t.wdata);
            end
        end
        if (rst_n && pass_done) pass_cnt++;
    end

    task automatic push(input logic we, input int a, input logic [71:0] d);
        txn_t t;
        t.we = we;
        t.addr = ADDR_W'(a);
        t.wdata = d;
        exp_q.push_back(t);
    endtask

    task automatic push_reads(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) push(1'b0, a, '0);
    endtask

    task automatic restore();
        for (int i = 0; i < DEPTH; i++) mem[i] = good(v[i]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits for pass_done; dropping enable in that cycle parks the block in IDLE at addr 0.
    task automatic run_pass(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (pass_done) seen = 1'b1;
        end
        enable = 1'b0;
        chk("pass_seen", seen, 1);
    endtask

    task automatic wait_reads(input int n, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (rd_times.size() >= n) seen = 1'b1;
        end
        chk("reads_seen", seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] bad1;
        bit          seen;
        restore();
        tick(3);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_dec_in", bus.dec_data_in, 0);
        chk("rst_counts", {ce_count, ue_count}, 0);
        chk("rst_ue", {ue_irq, ue_addr, pass_done}, 0);
        rst_n = 1'b1;
        tick(2);

        // Clean pass at interval 0: four reads, no writes, 5 cycles per word.
        push_reads(0, 3);
        enable = 1'b1;
        run_pass(100);
        tick(10);
        chk("clean_q_empty", exp_q.size(), 0);
        chk("clean_reads", rd_times.size(), 4);
        chk("clean_gap", rd_times[1] - rd_times[0], 5);
        chk("clean_pass_cnt", pass_cnt, 1);
        chk("clean_counts", {ce_count, ue_count, ue_irq}, 0);

        // Single-bit flip in word 2: one corrective write, one extra cycle.
        rd_times.delete();
        mem[2] = good(v[2]) ^ (72'd1 << 50);
        push_reads(0, 2);
        push(1'b1, 2, good(v[2]));
        push_reads(3, 3);
        enable = 1'b1;
        run_pass(100);
        tick(10);
        restore();
        chk("ce_q_empty", exp_q.size(), 0);
        chk("ce_count_1", ce_count, 1);
        chk("ce_no_irq", ue_irq, 0);
        chk("ce_gap", rd_times[3] - rd_times[2], 6);

        // Double-bit flips at 1 and 3: first UE address is held.
        mem[1] = good(v[1]) ^ (72'h3 << 40);
        mem[3] = good(v[3]) ^ (72'h5 << 60);
        push_reads(0, 3);
        enable = 1'b1;
        run_pass(100);
        tick(10);
        chk("ue_count_2", ue_count, 2);
        chk("ue_addr_1", ue_addr, 1);
        chk("ue_irq_set", ue_irq, 1);
        chk("ue_ce_unchanged", ce_count, 1);
        chk("ue_q_empty", exp_q.size(), 0);

        mem[1] = good(v[1]);
        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        tick(1);
        chk("irq_cleared", ue_irq, 0);
        chk("irq_clr_keeps_ce", ce_count, 1);
        push_reads(0, 3);
        enable = 1'b1;
        run_pass(100);
        tick(10);
        chk("rearm_ue_addr_3", ue_addr, 3);
        chk("rearm_ue_count", ue_count, 3);
        chk("rearm_irq", ue_irq, 1);
        mem[3] = good(v[3]);

        // irq_clr coinciding with a new UE (CHECK of word 1): the set wins.
        bad1 = good(v[1]) ^ (72'h3 << 40);
        mem[1] = bad1;
        push_reads(0, 3);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.dec_data_in == bad1) seen = 1'b1;
        end
        chk("check1_seen", seen, 1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        run_pass(100);
        tick(10);
        chk("clr_set_irq", ue_irq, 1);
        chk("clr_set_addr", ue_addr, 1);
        chk("clr_set_count", ue_count, 4);
        restore();

        // host_busy high for 10 cycles while the scrubber waits in READ.
        rd_times.delete();
        push_reads(0, 3);
        host_busy = 1'b1;
        enable = 1'b1;
        tick(10);
        host_busy = 1'b0;
        t_mark = cyc;
        run_pass(100);
        tick(10);
        chk("busy_reads", rd_times.size(), 4);
        chk("busy_first_read", rd_times[0], t_mark);
        chk("busy_q_empty", exp_q.size(), 0);

        // interval 5; enable dropped in RESP of word 1, then resumed.
        rd_times.delete();
        interval = 4'd5;
        push_reads(0, 1);
        enable = 1'b1;
        wait_reads(2, 100);
        enable = 1'b0;
        tick(40);
        chk("stop_reads", rd_times.size(), 2);
        chk("int5_gap", rd_times[1] - rd_times[0], 9);
        chk("stop_q_empty", exp_q.size(), 0);
        push_reads(2, 3);
        enable = 1'b1;
        t_mark = cyc;
        run_pass(200);
        tick(10);
        chk("resume_q_empty", exp_q.size(), 0);
        chk("resume_wait5", rd_times[2] - t_mark, 6);
        chk("resume_gap", rd_times[3] - rd_times[2], 9);

        // Repeated CEs drive the 4-bit counter from 1 to saturation.
        interval = '0;
        for (int p = 0; p < 4; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] = good(v[a]) ^ (72'd1 << 60);
                push(1'b0, a, '0);
                push(1'b1, a, good(v[a]));
            end
            enable = 1'b1;
            run_pass(200);
            tick(5);
            restore();
            if (p == 2) chk("ce_count_13", ce_count, 13);
        end
        chk("ce_saturated", ce_count, 4'hF);
        chk("sat_q_empty", exp_q.size(), 0);

        // Reset while a corrective write is stalled without grant.
        rd_times.delete();
        mem[0] = good(v[0]) ^ (72'd1 << 70);
        push(1'b0, 0, '0);
        push(1'b1, 0, good(v[0]));
        enable = 1'b1;
        wait_reads(1, 100);
        gnt_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_we && bus.mem_req) seen = 1'b1;
        end
        chk("write_stalled", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_req_we", {bus.mem_req, bus.mem_we}, 0);
        chk("arst_wdata", bus.mem_wdata, 0);
        chk("arst_dec_in", bus.dec_data_in, 0);
        chk("arst_counts", {ce_count, ue_count}, 0);
        chk("arst_ue", {ue_irq, ue_addr, pass_done, bus.mem_addr}, 0);
        exp_q.delete();
        tick(2);
        gnt_en = 1'b1;
        push(1'b0, 0, '0);
        push(1'b1, 0, good(v[0]));
        push_reads(1, 3);
        rst_n = 1'b1;
        run_pass(100);
        tick(10);
        restore();
        chk("restart_q_empty", exp_q.size(), 0);
        chk("restart_ce", ce_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
